ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED LED-set, 0xFF reset) from the FPGA to the keyboard.
- Runs on the same ps2_clk/ps2_data pair that ps2_keyboard receives on; it drives the lines open-drain through output enables.
- While a byte is being sent, the surrounding logic must hold off the receiver path.

---
 rtl/ps2_host_tx.sv | 167 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 transmitter.
// Sends one command byte to the keyboard over the shared ps2_clk/ps2_data pair,
// driving both lines open-drain through output enables (1 = pull low).
//
// Ports:
//   clk, clr            system clock, asynchronous active-high reset
//   ps2_clk, ps2_data   raw line read-back (unsynchronized)
//   ps2_clk_oe          1 = pull ps2_clk low
//   ps2_data_oe         1 = pull ps2_data low
//   tx_data, tx_valid   byte to send / request (taken only while tx_ready=1)
//   tx_ready            1 while idle
//   tx_done             one-cycle pulse: byte sent, device ack seen
//   tx_err              one-cycle pulse: transfer aborted
//   err_code            01 timeout, 10 no ack, 00 none; held until next accept
//
// INHIBIT_CYCLES is expected to be at least 2 so the data line can be pulled
// low on the last inhibit cycle while the clock is still held.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        r_state;
    logic [1:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    logic          r_clk_prev;
    logic [9:0]    r_frame;     // {stop, parity, data}, bit 0 goes out first
    logic [3:0]    r_bitcnt;
    logic [IW-1:0] r_inh_cnt;
    logic [TW-1:0] r_tmo_cnt;

    logic w_fall;
    logic w_timed;
    logic w_timeout;

    assign w_fall  = r_clk_prev & ~r_clk_sync[1];
    assign w_timed = (r_state == S_REQ) || (r_state == S_SEND) ||
                     (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
    // Counter is 0 in the first REQ cycle, so the abort registers on the edge
    // that completes TIMEOUT_CYCLES cycles since REQ entry.
    assign w_timeout = w_timed && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            // Syncs reset to the idle-high line level so no false fall is seen.
            r_clk_sync  <= 2'b11;
            r_dat_sync  <= 2'b11;
            r_clk_prev  <= 1'b1;
            r_state     <= S_IDLE;
            r_frame     <= '0;
            r_bitcnt    <= '0;
            r_inh_cnt   <= '0;
            r_tmo_cnt   <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            err_code    <= 2'b00;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
            r_clk_prev <= r_clk_sync[1];
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
            if (w_timed)
                r_tmo_cnt <= r_tmo_cnt + 1'b1;

            // Timeout takes priority over any fall seen in the same cycle.
            if (w_timeout) begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                tx_err      <= 1'b1;
                err_code    <= 2'b01;
                tx_ready    <= 1'b1;
                r_state     <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        if (tx_valid && tx_ready) begin
                            r_frame    <= {1'b1, ~^tx_data, tx_data};
                            err_code   <= 2'b00;
                            r_bitcnt   <= '0;
                            r_inh_cnt  <= '0;
                            tx_ready   <= 1'b0;
                            ps2_clk_oe <= 1'b1;
                            r_state    <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        r_inh_cnt <= r_inh_cnt + 1'b1;
                        // Data goes low one cycle before the clock is released.
                        if (r_inh_cnt == IW'(INHIBIT_CYCLES - 2))
                            ps2_data_oe <= 1'b1;
                        if (r_inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                            ps2_clk_oe <= 1'b0;
                            r_tmo_cnt  <= '0;
                            r_state    <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        // Start bit is on the line; the device reads it on its
                        // first rising clock, so the first fall just advances.
                        if (w_fall)
                            r_state <= S_SEND;
                    end
                    S_SEND: begin
                        if (w_fall) begin
                            ps2_data_oe <= ~r_frame[r_bitcnt];
                            r_bitcnt    <= r_bitcnt + 1'b1;
                            if (r_bitcnt == 4'd9)
                                r_state <= S_ACK;
                        end
                    end
                    S_ACK: begin
                        if (w_fall) begin
                            if (!r_dat_sync[1]) begin
                                r_state <= S_WAIT_IDLE;
                            end else begin
                                tx_err   <= 1'b1;
                                err_code <= 2'b10;
                                tx_ready <= 1'b1;
                                r_state  <= S_IDLE;
                            end
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (r_clk_sync[1] && r_dat_sync[1]) begin
                            tx_done  <= 1'b1;
                            tx_ready <= 1'b1;
                            r_state  <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// a scoreboard holds the expected outcome of each accepted request, and a
// monitor compares on every tx_done/tx_err pulse. The device clock is scaled
// up (HALF cycles per phase) to keep run time short.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 1000;
    localparam int HALF = 20;

    typedef struct packed {
        logic [7:0] data;
        logic       ok;
        logic [1:0] code;
        logic       tmo;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       ps2_clk_oe, ps2_data_oe, tx_ready, tx_done, tx_err;
    logic [1:0] err_code;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk_l, ps2_data_l;

    // Open-drain bus: either side may pull low.
    assign ps2_clk_l  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_l = ~(ps2_data_oe | dev_dat_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .clr(clr), .ps2_clk(ps2_clk_l), .ps2_data(ps2_data_l),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_done(tx_done), .tx_err(tx_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    exp_t        exp_q[$];
    logic [10:0] dev_q[$];
    int          dev_mode = 0;   // 0 ack, 1 no ack, 2 never clocks
    logic        dev_busy = 1'b0;
    int          dev_bits = 0;
    int          dev_frames = 0;
    int          n_resp = 0;
    logic [31:0] cyc = 0;
    logic [31:0] req_cyc = 0;
    logic [1:0]  last_code = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    // Reference frame as the device should see it on rising clocks:
    // start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = d[i];
            ones += int'(d[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Device model
    initial begin
        logic [10:0] rx;
        forever begin
            @(negedge clk);
            if (ps2_clk_oe) begin
                wait (!ps2_clk_oe);
                @(negedge clk);
                if (ps2_data_oe && dev_mode != 2) begin
                    dev_busy = 1'b1;
                    dev_bits = 0;
                    dev_frames++;
                    repeat (10) @(negedge clk);
                    for (int i = 0; i < 11; i++) begin
                        dev_clk_low = 1'b1;
                        repeat (HALF) @(negedge clk);
                        rx[i] = ps2_data_l;
                        dev_bits = i + 1;
                        dev_clk_low = 1'b0;
                        repeat (HALF) @(negedge clk);
                    end
                    dev_q.push_back(rx);
                    if (dev_mode == 0) dev_dat_low = 1'b1;
                    repeat (5) @(negedge clk);
                    dev_clk_low = 1'b1;
                    repeat (HALF) @(negedge clk);
                    dev_clk_low = 1'b0;
                    repeat (HALF / 2) @(negedge clk);
                    dev_dat_low = 1'b0;
                    repeat (HALF) @(negedge clk);
                    dev_busy = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        int   inh_run;
        logic prev_cloe, prev_doe, prev_pulse;
        exp_t e;
        inh_run = 0; prev_cloe = 1'b0; prev_doe = 1'b0; prev_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (ps2_clk_oe) begin
                inh_run++;
                prev_doe = ps2_data_oe;
            end else if (prev_cloe && !clr) begin
                check("inhibit_len", inh_run, INH);
                check("data_low_before_release", prev_doe, 1);
                req_cyc = cyc;
                inh_run = 0;
            end else begin
                inh_run = 0;
            end
            prev_cloe = ps2_clk_oe;

            if (tx_done || tx_err) begin
                n_resp++;
                check("done_err_exclusive", {31'd0, tx_done & tx_err}, 0);
                check("lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
                check("ready_after_resp", tx_ready, 1);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_response");
                end else begin
                    e = exp_q.pop_front();
                    check("resp_is_done", tx_done, e.ok);
                    check("err_code", err_code, e.code);
                    if (e.tmo)
                        check("timeout_latency", cyc - req_cyc, TMO);
                    else if (dev_q.size() == 0)
                        fail_now("no_frame_at_device");
                    else
                        check("frame_bits", dev_q.pop_front(), frame_bits(e.data));
                end
            end
            if (prev_pulse)
                check("pulse_one_cycle", {31'd0, tx_done | tx_err}, 0);
            prev_pulse = tx_done | tx_err;
        end
    end

    task automatic send(input logic [7:0] d, input int mode, input bit push);
        exp_t e;
        int t;
        dev_mode = mode;
        t = 0;
        while (!tx_ready && t < 5000) begin @(negedge clk); t++; end
        check("err_code_held", err_code, last_code);
        e.data = d;
        e.ok   = (mode == 0);
        e.code = (mode == 0) ? 2'b00 : (mode == 1) ? 2'b10 : 2'b01;
        e.tmo  = (mode == 2);
        if (push) exp_q.push_back(e);
        last_code = push ? e.code : 2'b00;
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("ready_low_after_accept", tx_ready, 0);
        check("err_code_clear_on_accept", err_code, 0);
    endtask

    task automatic wait_resp(input int n0);
        int t;
        t = 0;
        while (n_resp == n0 && t < 3000) begin @(negedge clk); t++; end
        if (n_resp == n0) fail_now("response_wait_expired");
    endtask

    task automatic wait_dev_idle();
        int t;
        t = 0;
        while (dev_busy && t < 3000) begin @(negedge clk); t++; end
        if (dev_busy) fail_now("device_idle_wait_expired");
    endtask

    task automatic wait_dev_mid();
        int t;
        t = 0;
        while (!(dev_busy && dev_bits >= 4) && t < 3000) begin @(negedge clk); t++; end
        if (!(dev_busy && dev_bits >= 4)) fail_now("device_mid_wait_expired");
    endtask

    task automatic xfer(input logic [7:0] d, input int mode);
        int n0;
        n0 = n_resp;
        send(d, mode, 1'b1);
        wait_resp(n0);
        wait_dev_idle();
    endtask

    initial begin
        int n0, f0;
        repeat (3) @(negedge clk);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_done", tx_done, 0);
        check("rst_err", tx_err, 0);
        check("rst_err_code", err_code, 0);
        clr = 1'b0;
        repeat (5) @(negedge clk);

        xfer(8'hED, 0);
        xfer(8'h02, 0);
        xfer(8'h00, 0);
        xfer(8'($urandom), 1);
        xfer(8'($urandom), 2);
        for (int i = 0; i < 6; i++)
            xfer(8'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0);

        // Request during SEND is dropped.
        f0 = dev_frames;
        n0 = n_resp;
        send(8'h3C, 0, 1'b1);
        wait_dev_mid();
        check("ready_low_in_send", tx_ready, 0);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_resp(n0);
        wait_dev_idle();
        repeat (200) @(negedge clk);
        check("single_frame_on_bus", dev_frames - f0, 1);
        check("no_second_request", ps2_clk_oe, 0);

        // Reset mid-SEND releases both lines immediately.
        send(8'h00, 0, 1'b0);
        wait_dev_mid();
        @(posedge clk);
        #2 clr = 1'b1;
        #1;
        check("clr_clk_oe", ps2_clk_oe, 0);
        check("clr_data_oe", ps2_data_oe, 0);
        check("clr_ready", tx_ready, 1);
        @(negedge clk);
        clr = 1'b0;
        wait_dev_idle();
        dev_q.delete();
        last_code = 2'b00;
        xfer(8'hFF, 0);

        repeat (20) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("device_queue_empty", dev_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
